mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the pipeline's single unified memory port between the instruction-fetch stage and the load/store (MEM) stage. It accepts level-held requests from both stages, grants one at a time with data-side priority, drives a variable-latency memory handshake, returns read data with one-cycle completion strobes and generates stall signals for the pipeline. A watchdog aborts transactions the memory never acknowledges and raises a sticky error flag.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles mem_req may stay high without mem_ready before abort (>=1)

One clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched word, valid when if_done, held afterwards
- if_done  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_done
- dm_rd  in  1  load request, held until dm_done
- dm_wr  in  1  store request, held until dm_done; wins over dm_rd if both high
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- dm_rdata  out  DATA_W  load data, valid when dm_done after a load, held afterwards
- dm_done  out  1  one-cycle data completion pulse
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done
- mem_req  out  1  memory request, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_size  out  2  registered size (fetch always 10)
- mem_ready  in  1  memory acknowledge; read data valid same cycle
- mem_rdata  in  DATA_W  memory read data
- bus_err  out  1  sticky timeout flag, cleared only by reset

## Operation
- States: IDLE, DATA, FETCH.
- IDLE: at clock edge, if a data request is pending (not masked), go to DATA; else if if_req is pending (not masked), go to FETCH; else stay. On entry, register mem_req=1, mem_addr, mem_we (=dm_wr for DATA, 0 for FETCH), mem_wdata, mem_size.
- Masking: in the cycle a requester's done is high, that requester's request is ignored by IDLE; this prevents re-issuing a completed request.
- DATA/FETCH: mem_* outputs hold stable. On mem_ready=1 at an edge: capture mem_rdata into dm_rdata (DATA load only) or if_rdata (FETCH), pulse the matching done next cycle, clear mem_req, return to IDLE.
- Stores do not modify dm_rdata.
- Watchdog: counter clears on grant, increments each busy cycle with mem_ready=0. When it reaches TIMEOUT, abort: mem_req drops, matching done pulses, captured rdata=0, bus_err set.
- Size/data pass-through only; no alignment or sign extension.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Reset mid-transaction drops mem_req asynchronously; no done pulse.
- Minimum latency: request first high in cycle t, mem_req high in t+1, mem_ready in t+1, done (and rdata) in t+2.
- Each wait cycle adds one cycle. Timeout: mem_req high for exactly TIMEOUT cycles, done in the following cycle.
- Back-to-back: the other requester may be granted at the edge ending the done cycle; mem_req is then low for exactly one cycle (the done cycle).
- Simultaneous if_req and data request in IDLE: DATA first, FETCH immediately after, never starved beyond one data transaction per pending fetch, since a newly arriving data request during FETCH waits.
- Stall outputs are combinational from the requests and registered done.

## Test plan
- Reset, then if_req=1, if_addr=0x100, mem_ready high in first request cycle, mem_rdata=0x00500093 -> mem_req high 1 cycle, if_done pulses at t+2, if_rdata=0x00500093, if_stall low from t+2.
- if_req and dm_rd (addr 0x2000, size 10) raised together -> data granted first, dm_done, one idle cycle, then fetch granted; if_stall high throughout until if_done.
- dm_wr=1, dm_rd=1, dm_wdata=0xDEADBEEF, size 00, mem_ready after 3 wait cycles -> mem_we=1, mem_size=00, dm_done 5 cycles after request, dm_rdata unchanged.
- Fetch with mem_ready never asserted, TIMEOUT=15 -> mem_req high 15 cycles, if_done pulses, if_rdata=0, bus_err=1 and stays 1 across later successful transactions.
- rst_n pulled low during a 2nd wait cycle -> mem_req, bus_err, done outputs 0 immediately; after release, held request re-granted normally.
- Requester holds if_req one cycle past if_done -> no duplicate mem_req issued from the masked cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one unified memory port between instruction fetch and
//            the load/store stage. Data side has priority. Drives a
//            variable-latency req/ready handshake, returns read data with
//            one-cycle done strobes, generates pipeline stalls, and aborts
//            transactions the memory never acknowledges (sticky bus_err).
// Ports    : clk, rst_n               - clock, async active-low reset
//            if_req/if_addr           - fetch request (level, held to done)
//            if_rdata/if_done/if_stall- fetch response and stall
//            dm_rd/dm_wr/dm_addr/dm_wdata/dm_size - load/store request
//            dm_rdata/dm_done/dm_stall- data response and stall
//            mem_req/mem_we/mem_addr/mem_wdata/mem_size - registered bus
//            mem_ready/mem_rdata      - memory acknowledge and read data
//            bus_err                  - sticky watchdog timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [1:0]        dm_size,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam int              c_cnt_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [1:0]      c_size_word = 2'b10;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_data  = 2'd1;
    localparam logic [1:0] c_st_fetch = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [1:0]         r_mem_size;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_dm_rdata;
    logic               r_if_done;
    logic               r_dm_done;
    logic               r_bus_err;

    logic               w_dm_req;
    logic               w_dm_pend;
    logic               w_if_pend;
    logic               w_busy;
    logic               w_timeout;
    logic               w_finish;
    logic [1:0]         w_dm_size;
    logic [DATA_W-1:0]  w_cap_data;

    // A requester whose done is high this cycle still holds its request;
    // masking it keeps IDLE from re-issuing the transaction just completed.
    assign w_dm_req  = dm_rd | dm_wr;
    assign w_dm_pend = w_dm_req & ~r_dm_done;
    assign w_if_pend = if_req & ~r_if_done;

    assign w_busy    = (r_state != c_st_idle);
    // The counter holds the number of elapsed wait cycles; the last one
    // allowed is TIMEOUT-1, so mem_req stays high exactly TIMEOUT cycles.
    assign w_timeout = w_busy & ~mem_ready & (r_cnt == c_cnt_last);
    assign w_finish  = w_busy & (mem_ready | w_timeout);

    // Aborted reads return zero rather than whatever is on the bus.
    assign w_cap_data = mem_ready ? mem_rdata : '0;
    // Size code 11 is presented to memory as a word access.
    assign w_dm_size  = (dm_size == 2'b11) ? c_size_word : dm_size;

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_dm_pend)      w_state_nxt = c_st_data;
                else if (w_if_pend) w_state_nxt = c_st_fetch;
            end
            c_st_data,
            c_st_fetch: begin
                if (w_finish) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------------
    // Bus, watchdog and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= 2'b00;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_cnt <= '0;
                    if (w_dm_pend) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_wr;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_mem_size  <= w_dm_size;
                    end else if (w_if_pend) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_size  <= c_size_word;
                    end
                end
                c_st_data,
                c_st_fetch: begin
                    if (w_finish) begin
                        r_mem_req <= 1'b0;
                        if (w_timeout) r_bus_err <= 1'b1;
                        if (r_state == c_st_fetch) begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= w_cap_data;
                        end else begin
                            r_dm_done <= 1'b1;
                            if (!r_mem_we) r_dm_rdata <= w_cap_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: r_mem_req <= 1'b0;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_size  = r_mem_size;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_done   = r_if_done;
    assign dm_done   = r_dm_done;
    assign bus_err   = r_bus_err;

    assign if_stall  = if_req & ~r_if_done;
    assign dm_stall  = w_dm_req & ~r_dm_done;

endmodule
`default_nettype wire
